// File: rtl/ce_rdwr_pkg.sv
// Shared types and constants for the ce/wr/rd strobe responder.
// Holds the FSM state encoding, counter ceiling and legal read-latency range.
package ce_rdwr_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    ERROR  = 2'd2
  } state_t;

  localparam logic [7:0] ACC_MAX    = 8'd255;
  localparam int         RD_LAT_MIN = 1;
  localparam int         RD_LAT_MAX = 4;

endpackage

// File: rtl/ce_rdwr_rd_pipe.sv
// Fixed-latency read return path: RD_LAT-deep shift register of {valid, data}.
// Entries are never stalled; reset flushes every stage so in-flight reads vanish.
module ce_rdwr_rd_pipe
  import ce_rdwr_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int RD_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_vld,
  input  logic [DATA_W-1:0] in_dat,
  output logic              out_vld,
  output logic [DATA_W-1:0] out_dat
);

  if (RD_LAT < RD_LAT_MIN || RD_LAT > RD_LAT_MAX) begin : g_bad_lat
    $fatal(1, "ce_rdwr_rd_pipe: RD_LAT must be within 1..4");
  end

  logic              vld_q [RD_LAT];
  logic              vld_d [RD_LAT];
  logic [DATA_W-1:0] dat_q [RD_LAT];
  logic [DATA_W-1:0] dat_d [RD_LAT];

  always_comb begin
    vld_d[0] = in_vld;
    dat_d[0] = in_vld ? in_dat : '0;
    for (int i = 1; i < RD_LAT; i++) begin
      vld_d[i] = vld_q[i-1];
      dat_d[i] = dat_q[i-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < RD_LAT; i++) begin
        vld_q[i] <= 1'b0;
        dat_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < RD_LAT; i++) begin
        vld_q[i] <= vld_d[i];
        dat_q[i] <= dat_d[i];
      end
    end
  end

  assign out_vld = vld_q[RD_LAT-1];
  assign out_dat = dat_q[RD_LAT-1];

endmodule

// File: rtl/ce_rdwr_responder.sv
// Memory-mapped responder for the ce/wr/rd strobe interface: register array, sticky
// wr/rd conflict error, fixed-latency read return, write ack and saturating access count.
module ce_rdwr_responder
  import ce_rdwr_pkg::*;
#(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8,
  parameter int RD_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ce,
  input  logic              wr,
  input  logic              rd,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              rvalid,
  output logic              wack,
  output logic              err,
  output logic [7:0]        acc_cnt
);

  localparam int DEPTH = 1 << ADDR_W;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic              wack_q, wack_d;
  logic [7:0]        acc_cnt_q, acc_cnt_d;

  logic              conflict;
  logic              acc_wr;
  logic              acc_rd;
  logic              pipe_vld;
  logic [DATA_W-1:0] pipe_dat;

  // A conflict always lands in ERROR, so "not ERROR and exactly one strobe" is sufficient.
  always_comb begin
    conflict = ce && wr && rd;
    acc_wr   = ce && (state_q != ERROR) && wr && !rd;
    acc_rd   = ce && (state_q != ERROR) && rd && !wr;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (conflict)  state_d = ERROR;
        else if (ce)   state_d = ACTIVE;
      end
      ACTIVE: begin
        if (!ce)            state_d = IDLE;
        else if (conflict)  state_d = ERROR;
      end
      ERROR: begin
        if (!ce) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) mem_d[i] = mem_q[i];
    if (acc_wr) mem_d[addr] = wdata;
    wack_d    = acc_wr;
    acc_cnt_d = acc_cnt_q;
    if ((acc_wr || acc_rd) && (acc_cnt_q != ACC_MAX)) acc_cnt_d = acc_cnt_q + 8'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      wack_q    <= 1'b0;
      acc_cnt_q <= 8'd0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      wack_q    <= wack_d;
      acc_cnt_q <= acc_cnt_d;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
    end
  end

  // Read data is taken from the pre-edge array; a write can never share the same edge.
  ce_rdwr_rd_pipe #(
    .DATA_W (DATA_W),
    .RD_LAT (RD_LAT)
  ) u_rd_pipe (
    .clk     (clk),
    .rst     (rst),
    .in_vld  (acc_rd),
    .in_dat  (mem_q[addr]),
    .out_vld (pipe_vld),
    .out_dat (pipe_dat)
  );

  assign rvalid  = pipe_vld;
  assign rdata   = pipe_vld ? pipe_dat : '0;
  assign wack    = wack_q;
  assign err     = (state_q == ERROR);
  assign acc_cnt = acc_cnt_q;

endmodule
